// File: rtl/btb_update_if.sv
// Result/redirect/BTB-write bundle between execute, fetch and the BTB update block.
// The slave modport is the update block; master is the execute/fetch/BTB side.
interface btb_update_if;
  logic        res_valid;
  logic        res_ready;
  logic [30:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic [31:0] res_fallthru;
  logic        res_pred_hit;
  logic [30:0] res_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        fetch_rd_req;
  logic        rd_blocked;
  logic        btb_wr;
  logic        btb_invalid;
  logic [30:0] pc_w;
  logic [31:0] target_pc_w;

  modport slave (
    input  res_valid, res_pc, res_taken, res_target, res_fallthru,
           res_pred_hit, res_pred_target, fetch_rd_req,
    output res_ready, mispredict, redirect_pc, rd_blocked,
           btb_wr, btb_invalid, pc_w, target_pc_w
  );

  modport master (
    output res_valid, res_pc, res_taken, res_target, res_fallthru,
           res_pred_hit, res_pred_target, fetch_rd_req,
    input  res_ready, mispredict, redirect_pc, rd_blocked,
           btb_wr, btb_invalid, pc_w, target_pc_w
  );
endinterface

// File: rtl/btb_update.sv
// BTB write side: classifies resolved branches, drives the fetch redirect and
// drains queued writes/invalidates into the single-port BTB behind fetch lookups.
module btb_update #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  btb_update_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic        inv;
    logic [30:0] pc;
    logic [31:0] tgt;
  } upd_t;

  upd_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, tail_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;

  logic empty, full, accept, is_upd, is_inv, enq, issue, coalesce, push;
  upd_t new_e, head;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign accept   = bus.res_valid & ~full;
  assign is_upd   = bus.res_taken &
                    (~bus.res_pred_hit | (bus.res_pred_target != bus.res_target[31:1]));
  assign is_inv   = ~bus.res_taken & bus.res_pred_hit;
  assign enq      = accept & (is_upd | is_inv);
  assign issue    = ~empty & (~bus.fetch_rd_req | (starve == SW'(STARVE_MAX)));
  assign tail_ptr = wr_ptr - AW'(1);
  assign head     = mem[rd_ptr];

  // The tail can only be popped when it is also the head (single entry).
  assign coalesce = enq & ~empty & (mem[tail_ptr].pc == bus.res_pc) &
                    ~(issue & (count == CW'(1)));
  assign push     = enq & ~coalesce;

  assign new_e.inv = is_inv;
  assign new_e.pc  = bus.res_pc;
  assign new_e.tgt = is_inv ? 32'h0 : bus.res_target;

  assign bus.res_ready  = ~full;
  // The BTB muxes the write address over the read port, so a write steals the lookup.
  assign bus.rd_blocked = bus.btb_wr & bus.fetch_rd_req;

  always_ff @(posedge clk) begin
    if (coalesce)  mem[tail_ptr] <= new_e;
    else if (push) mem[wr_ptr]   <= new_e;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      starve          <= '0;
      bus.mispredict  <= 1'b0;
      bus.redirect_pc <= '0;
      bus.btb_wr      <= 1'b0;
      bus.btb_invalid <= 1'b0;
      bus.pc_w        <= '0;
      bus.target_pc_w <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(issue);

      // Not issuing while non-empty implies fetch blocked us below the cap.
      if (empty || issue) starve <= '0;
      else                starve <= starve + SW'(1);

      bus.mispredict <= enq;
      if (enq) bus.redirect_pc <= is_upd ? bus.res_target : bus.res_fallthru;

      bus.btb_wr      <= issue;
      bus.btb_invalid <= issue & head.inv;
      bus.pc_w        <= issue ? head.pc  : 31'h0;
      bus.target_pc_w <= issue ? head.tgt : 32'h0;
    end
  end
endmodule

// File: tb/tb_btb_update.sv
// Directed plus randomized checks of btb_update against a queue-based reference model.
module tb_btb_update;
  localparam int DEPTH = 4;
  localparam int SMAX  = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  btb_update_if bus ();

  btb_update #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    bit        inv;
    bit [30:0] pc;
    bit [31:0] tgt;
  } ent_t;

  ent_t      q[$];
  int        starve;
  bit        e_mis, e_wr, e_inv;
  bit [31:0] e_red, e_tgt;
  bit [30:0] e_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    starve = 0;
    e_mis = 0; e_red = 0; e_wr = 0; e_inv = 0; e_pc = 0; e_tgt = 0;
  endtask

  task automatic drive(input bit v, input bit [30:0] pc, input bit tk, input bit [31:0] tgt,
                       input bit [31:0] ft, input bit hit, input bit [30:0] pt);
    bus.res_valid = v; bus.res_pc = pc; bus.res_taken = tk; bus.res_target = tgt;
    bus.res_fallthru = ft; bus.res_pred_hit = hit; bus.res_pred_target = pt;
  endtask

  task automatic idle();
    drive(0, 31'h0, 0, 32'h0, 32'h0, 0, 31'h0);
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    bit   acc, upd, inv, issue;
    ent_t h, e;
    #1;
    chk("res_ready", bus.res_ready, q.size() < DEPTH);
    chk("rd_blocked", bus.rd_blocked, e_wr && bus.fetch_rd_req);
    acc   = bus.res_valid && (q.size() < DEPTH);
    upd   = bus.res_taken && (!bus.res_pred_hit || bus.res_pred_target != bus.res_target[31:1]);
    inv   = !bus.res_taken && bus.res_pred_hit;
    issue = (q.size() > 0) && (!bus.fetch_rd_req || starve == SMAX);
    e_mis = acc && (upd || inv);
    if (e_mis) e_red = upd ? bus.res_target : bus.res_fallthru;
    if (q.size() == 0 || issue) starve = 0;
    else if (bus.fetch_rd_req && starve < SMAX) starve++;
    e_wr = issue; e_inv = 0;
    if (issue) begin
      h = q.pop_front();
      e_inv = h.inv; e_pc = h.pc; e_tgt = h.tgt;
    end
    if (e_mis) begin
      e.inv = inv; e.pc = bus.res_pc; e.tgt = inv ? 32'h0 : bus.res_target;
      if (q.size() > 0 && q[$].pc == e.pc) q[$] = e;
      else q.push_back(e);
    end
    @(posedge clk); #1;
    chk("mispredict", bus.mispredict, e_mis);
    chk("redirect_pc", bus.redirect_pc, e_red);
    chk("btb_wr", bus.btb_wr, e_wr);
    chk("btb_invalid", bus.btb_invalid, e_inv);
    if (e_wr) begin
      chk("pc_w", bus.pc_w, e_pc);
      chk("target_pc_w", bus.target_pc_w, e_tgt);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_mispredict", bus.mispredict, 0);
    chk("rst_redirect", bus.redirect_pc, 0);
    chk("rst_btb_wr", bus.btb_wr, 0);
    chk("rst_invalid", bus.btb_invalid, 0);
    chk("rst_pc_w", bus.pc_w, 0);
    chk("rst_target_w", bus.target_pc_w, 0);
    chk("rst_rd_blocked", bus.rd_blocked, 0);
    chk("rst_ready", bus.res_ready, 1);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    bus.fetch_rd_req = 0;
    model_reset();
    #3;
    pulse_reset();

    // Taken branch, BTB miss: redirect then write.
    drive(1, 31'h20, 1, 32'h100, 32'h44, 0, 31'h0); step(); idle();
    chk("s1_mis", bus.mispredict, 1);
    chk("s1_redirect", bus.redirect_pc, 32'h100);
    step();
    chk("s1_wr", bus.btb_wr, 1);
    chk("s1_inv", bus.btb_invalid, 0);
    chk("s1_pc_w", bus.pc_w, 31'h20);
    chk("s1_tgt_w", bus.target_pc_w, 32'h100);

    // Stale entry: not taken but hit -> invalidate.
    drive(1, 31'h22, 0, 32'h200, 32'h44, 1, 31'h100); step(); idle();
    chk("s2_redirect", bus.redirect_pc, 32'h44);
    step();
    chk("s2_wr", bus.btb_wr, 1);
    chk("s2_inv", bus.btb_invalid, 1);

    // Correct prediction: nothing happens.
    drive(1, 31'h24, 1, 32'h300, 32'h4c, 1, 31'h180); step(); idle();
    chk("s2_ok_mis", bus.mispredict, 0);
    step();
    chk("s2_ok_wr", bus.btb_wr, 0);

    // Starvation: fetch holds the port, write forced after the cap.
    bus.fetch_rd_req = 1;
    drive(1, 31'h30, 1, 32'h400, 32'h64, 0, 31'h0); step(); idle();
    for (int i = 0; i < SMAX; i++) begin
      step();
      chk("s3_blocked_wr", bus.btb_wr, 0);
    end
    step();
    chk("s3_forced_wr", bus.btb_wr, 1);
    chk("s3_rd_blocked", bus.rd_blocked, 1);
    // Counter restarted: a new entry again waits the full cap.
    drive(1, 31'h32, 1, 32'h480, 32'h68, 0, 31'h0); step(); idle();
    for (int i = 0; i < SMAX; i++) step();
    step();
    chk("s3_forced_wr2", bus.btb_wr, 1);

    // Fill the FIFO, stall the 5th result, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 31'h40 + 31'(i), 1, 32'h1000 + 32'(16 * i), 32'h0, 0, 31'h0);
      step();
    end
    drive(1, 31'h50, 1, 32'h2000, 32'h0, 0, 31'h0);
    #1;
    chk("s4_full_ready", bus.res_ready, 0);
    step(); idle();
    chk("s4_stall_mis", bus.mispredict, 0);
    bus.fetch_rd_req = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("s4_drain_wr", bus.btb_wr, 1);
      chk("s4_drain_pc", bus.pc_w, 31'h40 + 31'(i));
    end
    chk("s4_ready_after", bus.res_ready, 1);
    step();

    // Coalescing: latest target wins, single write.
    bus.fetch_rd_req = 1;
    drive(1, 31'h60, 1, 32'h200, 32'h0, 0, 31'h0); step();
    drive(1, 31'h60, 1, 32'h300, 32'h0, 0, 31'h0); step(); idle();
    bus.fetch_rd_req = 0;
    step();
    chk("s5_wr", bus.btb_wr, 1);
    chk("s5_tgt", bus.target_pc_w, 32'h300);
    step();
    chk("s5_single", bus.btb_wr, 0);

    // Reset with queued entries drops them.
    bus.fetch_rd_req = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 31'h70 + 31'(i), 1, 32'h500, 32'h0, 0, 31'h0);
      step();
    end
    idle();
    pulse_reset();
    bus.fetch_rd_req = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s6_no_wr", bus.btb_wr, 0);
    end

    // Random traffic on a small PC set to exercise coalescing, starvation and full.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, 31'h80 + 31'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) ? 32'h100 : 32'h200,
            32'h88, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) ? 31'h80 : 31'h100);
      bus.fetch_rd_req = ($urandom_range(0, 3) != 0);
      step();
    end
    idle();
    bus.fetch_rd_req = 0;
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
